// File: rtl/producer_consumer.sv
// Single-producer, four-consumer stream dispatcher with one circular FIFO per output lane.
// Build option: define PRODUCER_CONSUMER_RR_EN to route round-robin instead of by io_in_bits[1:0].
module producer_consumer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   input  logic [WIDTH-1:0] io_in_bits,
   output logic             io_in_ready,
   output logic             io_out_0_valid,
   output logic [WIDTH-1:0] io_out_0_bits,
   input  logic             io_out_0_ready,
   output logic             io_out_1_valid,
   output logic [WIDTH-1:0] io_out_1_bits,
   input  logic             io_out_1_ready,
   output logic             io_out_2_valid,
   output logic [WIDTH-1:0] io_out_2_bits,
   input  logic             io_out_2_ready,
   output logic             io_out_3_valid,
   output logic [WIDTH-1:0] io_out_3_bits,
   input  logic             io_out_3_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [4][DEPTH];
   logic [AW-1:0]    rd_ptr [4];
   logic [AW-1:0]    wr_ptr [4];
   logic [AW:0]      count  [4];
   logic [3:0]       full, empty, push, pop, out_ready;
   logic [1:0]       dest;
   logic             in_fire;

   assign out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

`ifdef PRODUCER_CONSUMER_RR_EN
   logic [1:0] rr_ptr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       rr_ptr <= 2'd0;
      else if (in_fire) rr_ptr <= rr_ptr + 2'd1;
   end

   assign dest = rr_ptr;
`else
   assign dest = io_in_bits[1:0];
`endif

   // A full FIFO refuses its word even when popped this cycle: no pass-through path.
   assign io_in_ready = !full[dest];
   assign in_fire     = io_in_valid && io_in_ready;

   always_comb begin
      push = '0;
      pop  = '0;
      full = '0;
      empty = '0;
      for (int k = 0; k < 4; k++) begin
         full[k]  = (count[k] == FULL_CNT);
         empty[k] = (count[k] == '0);
         pop[k]   = !empty[k] && out_ready[k];
      end
      if (in_fire) push[dest] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every FIFO sees pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            rd_ptr[k] <= '0;
            wr_ptr[k] <= '0;
            count[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
            if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
            case ({push[k], pop[k]})
               2'b10:   count[k] <= count[k] + CNT_ONE;
               2'b01:   count[k] <= count[k] - CNT_ONE;
               default: count[k] <= count[k];
            endcase
         end
      end
   end

   // NOTE: storage has no reset; pointers and counts alone decide what is valid.
   always_ff @(posedge clock) begin
      for (int k = 0; k < 4; k++)
         if (push[k]) mem[k][wr_ptr[k]] <= io_in_bits;
   end

   assign io_out_0_valid = !empty[0];
   assign io_out_1_valid = !empty[1];
   assign io_out_2_valid = !empty[2];
   assign io_out_3_valid = !empty[3];
   assign io_out_0_bits  = mem[0][rd_ptr[0]];
   assign io_out_1_bits  = mem[1][rd_ptr[1]];
   assign io_out_2_bits  = mem[2][rd_ptr[2]];
   assign io_out_3_bits  = mem[3][rd_ptr[3]];

endmodule

// File: tb/tb_producer_consumer.sv
// Self-checking bench for producer_consumer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference of the four output lanes.
module tb_producer_consumer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_bits = '0;
   logic             in_ready;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready = '0;
   logic [WIDTH-1:0] out_bits [4];

   producer_consumer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .io_in_valid    (in_valid),
      .io_in_bits     (in_bits),
      .io_in_ready    (in_ready),
      .io_out_0_valid (out_valid[0]),
      .io_out_0_bits  (out_bits[0]),
      .io_out_0_ready (out_ready[0]),
      .io_out_1_valid (out_valid[1]),
      .io_out_1_bits  (out_bits[1]),
      .io_out_1_ready (out_ready[1]),
      .io_out_2_valid (out_valid[2]),
      .io_out_2_bits  (out_bits[2]),
      .io_out_2_ready (out_ready[2]),
      .io_out_3_valid (out_valid[3]),
      .io_out_3_bits  (out_bits[3]),
      .io_out_3_ready (out_ready[3])
   );

   always #5 clock = ~clock;

   // Reference: one queue of pending words per lane, plus the round-robin turn counter.
   logic [WIDTH-1:0] q [4][$];
   int rr_turn = 0;
   int passed  = 0;
   int failed  = 0;
   int total   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_dest(input logic [WIDTH-1:0] bits);
`ifdef PRODUCER_CONSUMER_RR_EN
      return rr_turn % 4;
`else
      return int'(bits[1:0]);
`endif
   endfunction

   task automatic check_outputs();
      int d;
      d = model_dest(in_bits);
      check("in_ready", 32'(in_ready), 32'(q[d].size() < DEPTH));
      for (int k = 0; k < 4; k++) begin
         check($sformatf("out%0d_valid", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
         if (q[k].size() != 0)
            check($sformatf("out%0d_bits", k), 32'(out_bits[k]), 32'(q[k][0]));
      end
   endtask

   // One cycle: drive, check at posedge+2, clock, then advance the reference.
   task automatic step(input logic v, input logic [WIDTH-1:0] bits, input logic [3:0] rdy,
                       output bit accepted);
      int  d;
      bit  pops [4];
      in_valid  = v;
      in_bits   = bits;
      out_ready = rdy;
      #1;
      check_outputs();
      d = model_dest(bits);
      accepted = v && (q[d].size() < DEPTH);
      for (int k = 0; k < 4; k++) pops[k] = rdy[k] && (q[k].size() != 0);
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) if (pops[k]) void'(q[k].pop_front());
      if (accepted) begin
         q[d].push_back(bits);
         rr_turn++;
      end
   endtask

   task automatic flush_model();
      for (int k = 0; k < 4; k++) q[k].delete();
      rr_turn = 0;
   endtask

   initial begin
      bit acc;
      int n;

      // Reset state.
      reset = 1'b0;
      #12;
      check("reset_ready", 32'(in_ready), 32'd1);
      check("reset_valids", 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 4'b0000, acc);

      // Full throughput: 0x00..0x0F back to back, every consumer ready.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 4'b1111, acc);
         check("thru_accept", 32'(acc), 32'd1);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 4'b1111, acc);

      // Stalled consumer 1, then 0x11 blocked until lane 1 pops.
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 4'b1101, acc);
         check("stall_accept", 32'(acc), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h11, 4'b1101, acc);
         check("stall_block", 32'(acc), 32'd0);
      end
      n = 0;
      acc = 1'b0;
      while (!acc && n < 10) begin
         step(1'b1, 8'h11, 4'b1111, acc);
         if (!acc) n++;
      end
      check("unstall_cycle", 32'(n), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 4'b1111, acc);

      // Simultaneous push and pop on lane 2 holding three words.
      step(1'b1, 8'h02, 4'b1011, acc);
      step(1'b1, 8'h06, 4'b1011, acc);
      step(1'b1, 8'h0A, 4'b1011, acc);
      step(1'b1, 8'h22, 4'b1111, acc);
      check("pushpop_accept", 32'(acc), 32'd1);
      step(1'b1, 8'h0E, 4'b1011, acc);
      check("pushpop_room", 32'(acc), 32'd1);
      step(1'b1, 8'h12, 4'b1011, acc);
      check("pushpop_full", 32'(acc), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 4'b1111, acc);

      // Mid-stream reset with partly filled lanes.
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 4'b0000, acc);
      reset = 1'b0;
      #1;
      check("midreset_valids", 32'(out_valid), 32'd0);
      check("midreset_ready", 32'(in_ready), 32'd1);
      flush_model();
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 4'b1111, acc);

      // Five writes of 0x10 with consumers stalled (lane spread depends on routing build).
      for (int i = 0; i < 5; i++) step(1'b1, 8'h10, 4'b0000, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 4'b1111, acc);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] rdy;
         rdy = 4'($urandom) | 4'($urandom);
         if ((i / 50) % 2 == 1) rdy = rdy & 4'($urandom);
         step(($urandom % 4) != 0, 8'($urandom), rdy, acc);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 4'b1111, acc);
      for (int k = 0; k < 4; k++)
         check($sformatf("drained%0d", k), 32'(out_valid[k]), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/producer_consumer.md
# producer_consumer

Single-producer, four-consumer stream dispatcher. It accepts 8-bit data over one valid/ready input and steers each word to one of four valid/ready outputs, each backed by its own FIFO. Consumers drain independently. A stalled consumer back-pressures the producer only when a word targets that consumer's full FIFO. The block sits between a single data source and four parallel processing lanes.

## Interface
Parameters:
- `DEPTH`, default 4: entries per output FIFO; power of two, at least 2.
- `WIDTH`, default 8: data width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `io_in_valid`  in  1  producer word valid.
- `io_in_bits`  in  WIDTH  producer word.
- `io_in_ready`  out  1  block accepts the word this cycle.
- `io_out_k_valid`, k = 0..3  out  1  FIFO k non-empty.
- `io_out_k_bits`, k = 0..3  out  WIDTH  head of FIFO k.
- `io_out_k_ready`, k = 0..3  in  1  consumer k takes the head word.

## Operation
- Destination select: `dest = io_in_bits[1:0]`. This is the default; the Configuration section gives the alternative.
- Input readiness: `io_in_ready = !full[dest]`. It is combinational from `io_in_bits` and the FIFO state, and is independent of `io_in_valid`.
- Input transfer: occurs when `io_in_valid && io_in_ready`; the word is pushed into FIFO `dest`.
- Output transfer k: occurs when `io_out_k_valid && io_out_k_ready`; the head of FIFO k is popped.
- Each FIFO:
  - circular buffer with WIDTH-bit entries;
  - read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH;
  - occupancy counter of log2(DEPTH)+1 bits.
- FIFO status:
  - `full` when count equals DEPTH;
  - `empty` when count is 0.
- `io_out_k_valid = !empty[k]`.
- `io_out_k_bits` = memory[rdptr], driven directly from the storage array.
- Push and pop on the same FIFO in the same cycle: both take effect and the count is unchanged. This is legal whenever the FIFO is non-full.
- A full FIFO refuses the push even if it is popped in the same cycle; there is no pass-through.
- Ordering: strict FIFO order per output. No ordering relation exists across outputs.
- No data is dropped or duplicated under any combination of valid and ready.

## Timing
- Reset (`reset` low):
  - asynchronously clears all pointers and counts;
  - all `io_out_k_valid` = 0 and `io_in_ready` = 1;
  - `io_out_k_bits` are don't-care; the memory is not cleared.
- Reset asserted mid-operation flushes all FIFOs; in-flight words are discarded.
- Latency: a word accepted at rising edge t is visible on `io_out_dest` immediately after edge t, so it can be consumed at edge t+1.
- Throughput:
  - one input word per cycle;
  - each output sustains one word per cycle when ready is held high.
- Head-of-line blocking: when the input word targets a full FIFO, `io_in_ready` stays low. Words for other outputs wait behind it until that FIFO pops.
- Full-to-non-full: after a pop at edge t, `io_in_ready` for that destination rises right after edge t.

## Configuration
- Macro `PRODUCER_CONSUMER_RR_EN`.
- Defined: `dest` comes from a 2-bit round-robin pointer.
  - The pointer is reset to 0.
  - It increments modulo 4 on each input transfer.
  - `io_in_bits` is ignored for routing.
- Undefined: `dest = io_in_bits[1:0]`. Behaviour is otherwise identical in both builds.

## Test plan
- Reset check: hold `reset` low, then release. Required: all `io_out_k_valid` = 0 and `io_in_ready` = 1; no output valid rises without input.
- Full throughput: all outputs ready; write 0x00..0x0F back-to-back. Required:
  - `io_in_ready` stays 1 throughout;
  - out_0 emits 0,4,8,C; out_1 emits 1,5,9,D; out_2 emits 2,6,A,E; out_3 emits 3,7,B,F;
  - each word appears one cycle after acceptance.
- Stalled consumer: `io_out_1_ready` = 0, DEPTH = 4; write 0x00..0x0F, then 0x11. Required:
  - 0x00..0x0F are all accepted;
  - `io_in_ready` = 0 while 0x11 is presented;
  - after `io_out_1_ready` = 1, out_1 emits 1,5,9,D,11 in order, and 0x11 is accepted the cycle after the first pop.
- Simultaneous push and pop: FIFO 2 holds 3 words and out_2 is ready; push 0x22. Required: the count stays at 3 and order is preserved.
- Mid-stream reset: assert `reset` while FIFOs are partly filled. Required: all valids drop immediately and previously queued words are never emitted after release.
- `PRODUCER_CONSUMER_RR_EN` defined: write 0x10,0x10,0x10,0x10,0x10. Required: outputs 0,1,2,3,0 each receive one 0x10.
